// File: rtl/ep2_port_demux_pkg.sv
// rtl/ep2_port_demux_pkg.sv - EP2 demux parameters, header layout and state encoding shared with the arbitrator
package ep2_port_demux_pkg;

  localparam int EP2_NUM_PORTS  = 4;
  localparam int EP2_ADDR_WIDTH = 11;
  localparam int COUNT_WIDTH    = 32;

  localparam int HDR_PORT_OFS   = 0;
  localparam int HDR_LEN_HI_OFS = 1;
  localparam int HDR_LEN_LO_OFS = 2;
  localparam int HDR_BYTES      = 3;

  // Header states are numbered by the byte offset they consume.
  typedef enum logic [2:0] {
    ST_HEADER  = 3'(HDR_PORT_OFS),
    ST_LEN_HI  = 3'(HDR_LEN_HI_OFS),
    ST_LEN_LO  = 3'(HDR_LEN_LO_OFS),
    ST_PAYLOAD = 3'(HDR_BYTES),
    ST_DISCARD = 3'(HDR_BYTES + 1)
  } demux_state_e;

endpackage

// File: rtl/ep2_header_parser.sv
// rtl/ep2_header_parser.sv - EP2 packet sequencing: header fields, payload length and bad-packet discard
module ep2_header_parser
  import ep2_port_demux_pkg::*;
#(
  parameter int NUM_PORTS = EP2_NUM_PORTS,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              xfer,
  output demux_state_e      state,
  output logic [PORT_W-1:0] port,
  output logic              payload_xfer,
  output logic [7:0]        err_count
);

  localparam logic [8:0] PORT_LIMIT = 9'(NUM_PORTS);

  demux_state_e state_next;
  logic         bad;
  logic [7:0]   len_hi;
  logic [15:0]  remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_HEADER;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (xfer) begin
      unique case (state)
        ST_HEADER: state_next = ST_LEN_HI;
        ST_LEN_HI: state_next = ST_LEN_LO;
        ST_LEN_LO: begin
          if ({len_hi, in_data} == 16'd0) begin
            state_next = ST_HEADER;
          end else if (bad) begin
            state_next = ST_DISCARD;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD, ST_DISCARD: begin
          if (remaining == 16'd1) begin
            state_next = ST_HEADER;
          end
        end
        default: state_next = ST_HEADER;
      endcase
    end
  end

  always_comb begin
    payload_xfer = xfer && (state == ST_PAYLOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port      <= '0;
      bad       <= 1'b0;
      len_hi    <= 8'd0;
      remaining <= 16'd0;
      err_count <= 8'd0;
    end else if (xfer) begin
      case (state)
        ST_HEADER: begin
          port <= in_data[PORT_W-1:0];
          bad  <= {1'b0, in_data} >= PORT_LIMIT;
        end
        ST_LEN_HI: len_hi <= in_data;
        ST_LEN_LO: begin
          remaining <= {len_hi, in_data};
          // Counted here so a bad zero-length packet is still reported.
          if (bad && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
          end
        end
        ST_PAYLOAD, ST_DISCARD: remaining <= remaining - 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ep2_port_demux.sv
// rtl/ep2_port_demux.sv - routes EP2 packet payloads into per-port FIFO RAMs with pointer and byte-count tracking
module ep2_port_demux
  import ep2_port_demux_pkg::*;
#(
  parameter int NUM_PORTS  = EP2_NUM_PORTS,
  parameter int ADDR_WIDTH = EP2_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [NUM_PORTS-1:0]             fifo_we,
  output logic [ADDR_WIDTH-1:0]            fifo_waddr,
  output logic [7:0]                       fifo_wdata,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]  fifo_in_addrs,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  fifo_out_addrs,
  output logic [NUM_PORTS*COUNT_WIDTH-1:0] byte_counts,
  output logic [7:0]                       err_count
);

  localparam int                   PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [NUM_PORTS-1:0] WE_ONE = NUM_PORTS'(1);

  demux_state_e      state;
  logic [PORT_W-1:0] port;
  logic              xfer;
  logic              payload_xfer;
  logic              full;

  logic [ADDR_WIDTH-1:0]  wptr     [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]  in_addr  [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]  out_addr [NUM_PORTS];
  logic [COUNT_WIDTH-1:0] byte_cnt [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_pack
    assign out_addr[g] = fifo_out_addrs[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign fifo_in_addrs[g*ADDR_WIDTH +: ADDR_WIDTH] = in_addr[g];
    assign byte_counts[g*COUNT_WIDTH +: COUNT_WIDTH] = byte_cnt[g];
  end

  // One slot is kept empty so that wptr == out_addr always means empty.
  assign full     = (wptr[port] + ADDR_WIDTH'(1)) == out_addr[port];
  assign in_ready = (state != ST_PAYLOAD) || !full;
  assign xfer     = in_valid && in_ready;

  ep2_header_parser #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_parser (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .xfer         (xfer),
    .state        (state),
    .port         (port),
    .payload_xfer (payload_xfer),
    .err_count    (err_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_we    <= '0;
      fifo_waddr <= '0;
      fifo_wdata <= 8'd0;
      for (int g = 0; g < NUM_PORTS; g++) begin
        wptr[g]     <= '0;
        in_addr[g]  <= '0;
        byte_cnt[g] <= '0;
      end
    end else begin
      fifo_we <= '0;
      // Published a cycle late so the RAM write lands before the arbitrator sees it.
      for (int g = 0; g < NUM_PORTS; g++) begin
        in_addr[g] <= wptr[g];
      end
      if (payload_xfer) begin
        fifo_we        <= WE_ONE << port;
        fifo_waddr     <= wptr[port];
        fifo_wdata     <= in_data;
        wptr[port]     <= wptr[port] + ADDR_WIDTH'(1);
        byte_cnt[port] <= byte_cnt[port] + COUNT_WIDTH'(1);
      end
    end
  end

endmodule
